// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decoder state encoding.
// Used by the VGA timing generator and the sync decoder as parameter defaults.
package vga_timing_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_TOTAL      = 800;
    localparam int V_VISIBLE    = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_TOTAL      = 525;
    localparam int SYNC_STAGES  = 2;
    localparam int LOCK_LINES   = 2;

    typedef enum logic [1:0] {
        SEARCH,
        HLOCK,
        VCHECK,
        LOCKED
    } dec_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Synchronizer chain plus falling-edge pulse for one active-low sync input.
// Ports: clk, rst (async, active low), din (raw sync), fall_o (1-cycle pulse).
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // Idle level of a sync line is high, so preset everything to 1 to
    // avoid a false fall straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers h/v counts from incoming hsync/vsync and tracks 640x480 lock.
// Ports: clk, rst (async, active low), hsync, vsync in; h_cnt, v_cnt,
// valid, locked, frame_start, err_cnt out (all registered).
module vga_sync_decoder #(
    parameter int H_VISIBLE    = vga_timing_pkg::H_VISIBLE,
    parameter int H_SYNC_START = vga_timing_pkg::H_SYNC_START,
    parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter int V_VISIBLE    = vga_timing_pkg::V_VISIBLE,
    parameter int V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter int SYNC_STAGES  = vga_timing_pkg::SYNC_STAGES,
    parameter int LOCK_LINES   = vga_timing_pkg::LOCK_LINES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] err_cnt
);

    import vga_timing_pkg::*;

    localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0]  H_SS      = 10'(H_SYNC_START);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SS      = 10'(V_SYNC_START);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] LINE_LEN  = 11'(H_TOTAL);
    localparam logic [10:0] LINE_MAX  = 11'(2 * H_TOTAL);
    localparam logic [9:0]  FRAME_LEN = 10'(V_TOTAL);
    localparam logic [9:0]  FRAME_MAX = '1;
    localparam int          GC_W      = $clog2(LOCK_LINES + 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_LINES - 1);

    logic hs_fall;
    logic vs_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_hs (
        .clk    (clk),
        .rst    (rst),
        .din    (hsync),
        .fall_o (hs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_vs (
        .clk    (clk),
        .rst    (rst),
        .din    (vsync),
        .fall_o (vs_fall)
    );

    dec_state_e      state_q, state_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic [10:0]     line_len_q, line_len_d;
    logic [9:0]      frame_len_q, frame_len_d;
    logic [GC_W-1:0] good_cnt_q, good_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            locked_q, locked_d;
    logic            valid_q, valid_d;
    logic            fstart_q, fstart_d;

    logic h_wrap;
    logic line_good, line_bad;
    logic frame_good, frame_bad;
    logic h_lost;

    always_comb begin
        h_wrap = !hs_fall && (h_cnt_q == H_LAST);

        if (hs_fall)     h_cnt_d = H_SS;
        else if (h_wrap) h_cnt_d = '0;
        else             h_cnt_d = h_cnt_q + 10'd1;

        // A vsync fall lands on the same cycle as the h wrap; the load wins.
        if (vs_fall)     v_cnt_d = V_SS;
        else if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        else             v_cnt_d = v_cnt_q;

        // Starts at 1 so that it reads exactly H_TOTAL at the next fall.
        if (hs_fall)                    line_len_d = 11'd1;
        else if (line_len_q == LINE_MAX) line_len_d = LINE_MAX;
        else                            line_len_d = line_len_q + 11'd1;

        // The wrap coincident with a vsync fall opens the new frame count.
        if (vs_fall)
            frame_len_d = {9'd0, h_wrap};
        else if (h_wrap && frame_len_q != FRAME_MAX)
            frame_len_d = frame_len_q + 10'd1;
        else
            frame_len_d = frame_len_q;

        line_good  = hs_fall && (line_len_q == LINE_LEN);
        line_bad   = hs_fall && (line_len_q != LINE_LEN);
        frame_good = vs_fall && (frame_len_q == FRAME_LEN);
        frame_bad  = vs_fall && (frame_len_q != FRAME_LEN);
        h_lost     = (line_len_q == LINE_MAX);
    end

    // Failures are tested before any success so they take priority.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            SEARCH: begin
                if (line_bad || h_lost) begin
                    good_cnt_d = '0;
                end else if (line_good) begin
                    if (good_cnt_q == GC_LAST) begin
                        state_d    = HLOCK;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            HLOCK: begin
                if (line_bad || h_lost) state_d = SEARCH;
                else if (vs_fall)       state_d = VCHECK;
            end
            VCHECK: begin
                if (line_bad || h_lost || frame_bad) state_d = SEARCH;
                else if (frame_good)                state_d = LOCKED;
            end
            LOCKED: begin
                if (line_bad || h_lost || frame_bad) begin
                    state_d   = SEARCH;
                    err_cnt_d = sat_inc8(err_cnt_q);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Built from next-state values so they line up with h_cnt/v_cnt.
    always_comb begin
        locked_d = (state_d == LOCKED);
        valid_d  = locked_d && (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        fstart_d = locked_d && (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_len_q  <= '0;
            frame_len_q <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            fstart_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_len_q  <= line_len_d;
            frame_len_q <= frame_len_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            valid_q     <= valid_d;
            fstart_q    <= fstart_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign valid       = valid_q;
    assign locked      = locked_q;
    assign frame_start = fstart_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 16x6 line raster
// (96 clocks per frame) so many frames fit in a short run.
module tb_vga_sync_decoder;

    localparam int HV  = 10;
    localparam int HSS = 12;
    localparam int HT  = 16;
    localparam int VV  = 3;
    localparam int VSS = 4;
    localparam int VT  = 6;

    logic       clk;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       locked;
    logic       frame_start;
    logic [7:0] err_cnt;

    vga_sync_decoder #(
        .H_VISIBLE    (HV),
        .H_SYNC_START (HSS),
        .H_TOTAL      (HT),
        .V_VISIBLE    (VV),
        .V_SYNC_START (VSS),
        .V_TOTAL      (VT),
        .SYNC_STAGES  (2),
        .LOCK_LINES   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .locked      (locked),
        .frame_start (frame_start),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int k       = 0;
    int gen_h   = 0;
    int gen_v   = 0;
    int gen_vtot = VT;
    bit gen_short = 0;
    bit force_hs  = 0;
    int hist_h[4];
    int hist_v[4];

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One pixel clock of the generator model; outputs of the DUT seen after
    // this correspond to the generator position three steps earlier.
    task step();
        @(posedge clk);
        #1;
        k++;
        gen_h++;
        if (gen_h >= (gen_short ? HT - 1 : HT)) begin
            gen_h     = 0;
            gen_short = 0;
            gen_v++;
            if (gen_v >= gen_vtot) gen_v = 0;
        end
        hsync = force_hs ? 1'b1 : !((gen_h >= HSS) && (gen_h < HSS + 2));
        vsync = !(gen_v == VSS);
        hist_h[k % 4] = gen_h;
        hist_v[k % 4] = gen_v;
    endtask

    task wait_lock(input logic want, input int bound, output int n);
        n = 0;
        while (locked !== want && n < bound) begin
            step();
            n++;
        end
    endtask

    task seek(input int h, input int v);
        int n;
        n = 0;
        while (!(gen_h == h && gen_v == v) && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int hv_bad, valid_bad, fs_bad, drop_cnt;
        int valid_cnt, fs_cnt, fs_last, fs_period;
        int eh, ev;
        bit lock_seen;
        bit sat_ok;

        for (int i = 0; i < 4; i++) begin
            hist_h[i] = 0;
            hist_v[i] = 0;
        end
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_h_cnt", h_cnt, 0);
        chk("rst_v_cnt", v_cnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Generator starts at (0,0); lock at 2nd vsync fall (gen 160) + 3.
        rst = 1'b1;
        wait_lock(1'b1, 400, n);
        chk("lock_time", n, 163);

        hv_bad = 0; valid_bad = 0; fs_bad = 0; drop_cnt = 0;
        valid_cnt = 0; fs_cnt = 0; fs_last = -1; fs_period = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step();
            eh = hist_h[(k + 1) % 4];
            ev = hist_v[(k + 1) % 4];
            if (h_cnt !== 10'(eh) || v_cnt !== 10'(ev)) hv_bad++;
            if (valid !== ((eh < HV) && (ev < VV))) valid_bad++;
            if (frame_start !== (eh == 0 && ev == 0)) fs_bad++;
            if (locked !== 1'b1) drop_cnt++;
            if (valid === 1'b1) valid_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_last >= 0) fs_period = k - fs_last;
                fs_last = k;
            end
        end
        chk("hv_track", hv_bad, 0);
        chk("valid_track", valid_bad, 0);
        chk("fs_track", fs_bad, 0);
        chk("locked_steady", drop_cnt, 0);
        chk("valid_count", valid_cnt, 2 * HV * VV);
        chk("fs_count", fs_cnt, 2);
        chk("fs_period", fs_period, HT * VT);
        chk("err_clean", err_cnt, 0);

        // Line 0 shortened by one clock: drop at line 1 fall.
        seek(0, 0);
        gen_short = 1;
        wait_lock(1'b0, 100, n);
        chk("short_drop_delay", n, 30);
        chk("short_err", err_cnt, 1);
        wait_lock(1'b1, 400, n);
        chk("short_relock_delay", n, 132);
        chk("short_err_hold", err_cnt, 1);

        // hsync stuck high while locked, then again while searching.
        force_hs = 1;
        repeat (50) step();
        chk("timeout_locked", locked, 0);
        chk("timeout_err", err_cnt, 2);
        force_hs = 0;
        repeat (40) step();
        force_hs = 1;
        repeat (50) step();
        chk("timeout2_locked", locked, 0);
        chk("timeout2_err", err_cnt, 2);
        force_hs = 0;
        wait_lock(1'b1, 400, n);
        chk("timeout_relock", locked, 1);

        // Asynchronous reset mid-frame while locked.
        seek(5, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_h_cnt", h_cnt, 0);
        chk("mid_rst_v_cnt", v_cnt, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_frame_start", frame_start, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        repeat (3) step();
        chk("mid_rst_hold", {h_cnt, 7'd0, locked}, 0);
        rst = 1'b1;

        // The frame in progress has one line too few: VCHECK must fail.
        gen_vtot = VT - 1;
        lock_seen = 0;
        n = 0;
        while (!(gen_h == 0 && gen_v == 0) && n < 300) begin
            step();
            n++;
            if (locked === 1'b1) lock_seen = 1;
        end
        gen_vtot = VT;
        n = 0;
        while (!(gen_h == 0 && gen_v == VT - 1) && n < 300) begin
            step();
            n++;
            if (locked === 1'b1) lock_seen = 1;
        end
        chk("short_frame_no_lock", lock_seen, 0);
        chk("short_frame_err", err_cnt, 0);
        wait_lock(1'b1, 400, n);
        chk("short_frame_relock", locked, 1);

        // Drive err_cnt to its ceiling and one step beyond.
        sat_ok = 1;
        for (int i = 0; i < 255 && sat_ok; i++) begin
            gen_short = 1;
            wait_lock(1'b0, 100, n);
            if (locked !== 1'b0) sat_ok = 0;
            wait_lock(1'b1, 400, n);
            if (locked !== 1'b1) sat_ok = 0;
        end
        chk("sat_loop", sat_ok, 1);
        chk("err_255", err_cnt, 255);
        gen_short = 1;
        wait_lock(1'b0, 100, n);
        chk("sat_drop", locked, 0);
        chk("err_hold_255", err_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes hsync/vsync on the pixel clock and reconstructs h_cnt/v_cnt, valid and frame markers.
- Checks the incoming timing against 640x480@60 and reports lock and error status.
- Used for loop-back checking of the display path and as the front end of a future capture path.

Parameters:
H_VISIBLE, 640, active pixels per line
H_SYNC_START, 656, h count at hsync falling edge (visible + front porch)
H_TOTAL, 800, pixel clocks per line
V_VISIBLE, 480, active lines per frame
V_SYNC_START, 490, v count at vsync falling edge
V_TOTAL, 525, lines per frame
SYNC_STAGES, 2, input synchronizer depth (>=1)
LOCK_LINES, 2, consecutive correct line periods needed for horizontal lock

Ports:
clk  input  1  pixel clock (25 MHz)
rst  input  1  asynchronous, active-low reset (asserted at 0)
hsync  input  1  horizontal sync, active low
vsync  input  1  vertical sync, active low
h_cnt  output  10  recovered horizontal count, 0..H_TOTAL-1
v_cnt  output  10  recovered vertical count, 0..V_TOTAL-1
valid  output  1  locked and inside the visible area
locked  output  1  full horizontal and vertical lock
frame_start  output  1  one-cycle pulse at recovered (0,0) while locked
err_cnt  output  8  count of lock losses, saturates at 255

Behaviour:
- Reset values: all outputs 0; state SEARCH; all counters 0; synchronizer flops and edge-detect history preset to 1 (sync idle).
- Inputs pass through SYNC_STAGES flops to give hsync_s/vsync_s. A fall is hsync_s==0 with previous sample 1; vsync falls are detected the same way.
- Recovered counts lag the transmitter by SYNC_STAGES+1 cycles. This is fixed and documented.
- h_cnt: on the cycle after an hsync fall it equals H_SYNC_START. Otherwise it increments each clock and wraps H_TOTAL-1 -> 0.
- v_cnt: increments on every h wrap and wraps V_TOTAL-1 -> 0. On a vsync fall it loads V_SYNC_START; the load wins over a coincident h wrap.
- Period checks:
  - line_len counts clocks since the last hsync fall (saturates at 2*H_TOTAL). A line is good when line_len==H_TOTAL at the next fall.
  - frame_len counts h wraps since the last vsync fall. A frame is good when frame_len==V_TOTAL at the next vsync fall.
- FSM:
  - SEARCH: after LOCK_LINES consecutive good lines -> HLOCK. A bad line resets the good-line count.
  - HLOCK: the first vsync fall -> VCHECK (starts frame_len). A bad line -> SEARCH.
  - VCHECK: a good frame at the next vsync fall -> LOCKED. A bad frame or bad line -> SEARCH.
  - LOCKED: a bad line, bad frame, or line_len reaching 2*H_TOTAL (hsync lost) -> SEARCH, and err_cnt increments unless it is already 255.
  - SEARCH/HLOCK/VCHECK: line_len timeout returns to SEARCH without incrementing err_cnt.
- Outputs:
  - locked = (state==LOCKED), registered.
  - valid = locked && h_cnt<H_VISIBLE && v_cnt<V_VISIBLE, aligned with h_cnt/v_cnt.
  - frame_start = locked && h_cnt==0 && v_cnt==0.
- When lock drops, h_cnt/v_cnt keep free-running; valid and frame_start go low the same cycle locked falls.
- Simultaneous hsync and vsync falls: both checks are evaluated in the same cycle. Any failure takes priority over a success transition.
- Reset asserted mid-frame: immediate return to reset values. After release a full reacquisition is required.
- Widths: all count comparisons are unsigned and 10/11-bit wide enough. line_len is 11 bits.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480 timing constants (H_VISIBLE..V_TOTAL). The generator and decoder both take their parameter defaults from it.
- It also holds the state enum {SEARCH, HLOCK, VCHECK, LOCKED}.
- One natural sub-module: sync_edge_detect (synchronizer chain plus falling-edge pulse), instantiated twice.

Test Plan:
- Clean 640x480 stream from the generator model: locked rises at the second vsync fall after reset release. Once locked, frame_start pulses every 420000 clocks.
- Once locked, valid is high for exactly 640*480=307200 cycles per frame. h_cnt/v_cnt equal the generator counts delayed by SYNC_STAGES+1=3 cycles.
- One line shortened to 799 clocks while locked: locked drops on that hsync fall, err_cnt goes 0 -> 1, and relock follows within about one frame.
- hsync held high for 1600+ clocks while locked: timeout -> SEARCH and err_cnt increments. In SEARCH a second timeout leaves err_cnt unchanged.
- Frame of 524 lines while in VCHECK: the state returns to SEARCH, locked never asserts, and err_cnt is unchanged.
- rst pulsed low mid-frame while locked: all outputs are 0 immediately. Force 256 lock losses: err_cnt holds at 255.
